// File: rtl/uart_pkg.sv
// Shared encodings for the UART RX frame checker: parity modes and FSM states.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_EVEN  = 2'b00,
        PAR_ODD   = 2'b01,
        PAR_MARK  = 2'b10,
        PAR_SPACE = 2'b11
    } par_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DATA   = 3'd1,
        ST_PARITY = 3'd2,
        ST_STOP1  = 3'd3,
        ST_STOP2  = 3'd4,
        ST_DONE   = 3'd5
    } rx_state_e;

    // Parity bit the transmitter should have sent, given the XOR of the data bits.
    function automatic logic exp_parity(par_mode_e mode, logic data_xor);
        logic p;
        p = 1'b0;
        unique case (mode)
            PAR_EVEN:  p = data_xor;
            PAR_ODD:   p = ~data_xor;
            PAR_MARK:  p = 1'b1;
            PAR_SPACE: p = 1'b0;
            default:   p = 1'b0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; a clear in the same cycle as an increment yields 1.
module sat_counter #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            count <= '0;
        else if (clr)
            count <= inc ? CNT_WIDTH'(1) : '0;
        else if (inc && (count != '1))
            count <= count + CNT_WIDTH'(1);
    end

endmodule

// File: rtl/uart_rx_frame_check.sv
// UART RX frame checker: assembles LSB-first data bits, checks parity and stop bits,
// and presents each completed word with error flags and saturating error counts.
module uart_rx_frame_check
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frm_start,
    input  logic                  frm_abort,
    input  logic                  bit_valid,
    input  logic                  sampled_bit,
    input  logic                  par_en,
    input  logic [1:0]            par_mode,
    input  logic                  stop_two,
    input  logic                  err_clr,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic [CNT_WIDTH-1:0]  par_err_cnt,
    output logic [CNT_WIDTH-1:0]  stp_err_cnt,
    output logic                  busy
);

    localparam int            BCW      = $clog2(DATA_WIDTH + 1);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

    rx_state_e             state, state_nx;
    logic [DATA_WIDTH-1:0] shreg;
    logic [BCW-1:0]        bit_cnt;
    logic                  run_par;
    logic                  par_f, par_nx;
    logic                  stp_f, stp_nx;
    logic                  load;
    logic                  par_en_q;
    par_mode_e             par_mode_q;
    logic                  stop_two_q;

    always_comb begin
        state_nx = state;
        par_nx   = par_f;
        stp_nx   = stp_f;
        load     = 1'b0;
        unique case (state)
            ST_IDLE:
                if (frm_start) state_nx = ST_DATA;
            ST_DATA:
                if (bit_valid && (bit_cnt == LAST_BIT))
                    state_nx = par_en_q ? ST_PARITY : ST_STOP1;
            ST_PARITY:
                if (bit_valid) begin
                    par_nx   = sampled_bit ^ exp_parity(par_mode_q, run_par);
                    state_nx = ST_STOP1;
                end
            ST_STOP1:
                if (bit_valid) begin
                    stp_nx = ~sampled_bit;
                    if (stop_two_q) begin
                        state_nx = ST_STOP2;
                    end else begin
                        state_nx = ST_DONE;
                        load     = 1'b1;
                    end
                end
            ST_STOP2:
                if (bit_valid) begin
                    stp_nx   = stp_f | ~sampled_bit;
                    state_nx = ST_DONE;
                    load     = 1'b1;
                end
            ST_DONE:
                state_nx = ST_IDLE;
            default:
                state_nx = ST_IDLE;
        endcase
        // Abort beats every transition, including the final stop bit.
        if (frm_abort && (state != ST_IDLE)) begin
            state_nx = ST_IDLE;
            load     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            run_par    <= 1'b0;
            par_f      <= 1'b0;
            stp_f      <= 1'b0;
            par_en_q   <= 1'b0;
            par_mode_q <= PAR_EVEN;
            stop_two_q <= 1'b0;
            p_data     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
        end else begin
            state      <= state_nx;
            data_valid <= load;
            par_f      <= par_nx;
            stp_f      <= stp_nx;
            if ((state == ST_IDLE) && frm_start) begin
                par_en_q   <= par_en;
                par_mode_q <= par_mode_e'(par_mode);
                stop_two_q <= stop_two;
                bit_cnt    <= '0;
                run_par    <= 1'b0;
                par_f      <= 1'b0;
                stp_f      <= 1'b0;
            end
            if ((state == ST_DATA) && bit_valid && !frm_abort) begin
                shreg   <= {sampled_bit, shreg[DATA_WIDTH-1:1]};
                run_par <= run_par ^ sampled_bit;
                bit_cnt <= bit_cnt + BCW'(1);
            end
            if (load) begin
                p_data  <= shreg;
                par_err <= par_en_q & par_nx;
                stp_err <= stp_nx;
            end
        end
    end

    assign busy = (state != ST_IDLE);

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_par_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (data_valid & par_err),
        .clr   (err_clr),
        .count (par_err_cnt)
    );

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stp_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (data_valid & stp_err),
        .clr   (err_clr),
        .count (stp_err_cnt)
    );

endmodule
